// File: rtl/pc_trace_pkg.sv
// Shared types for the PC trace monitor: channel states and the trace record layout.
// Record fields are sized for the largest supported configuration; unused upper bits are constant.
package pc_trace_pkg;

  localparam int HIT_W     = 16;
  localparam int CH_W_MAX  = 4;
  localparam int CYC_W_MAX = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } ch_state_e;

  typedef struct packed {
    logic [CH_W_MAX-1:0]  ch;
    logic [CYC_W_MAX-1:0] cycle;
    logic [31:0]          value;
    logic [HIT_W-1:0]     hit;
  } trace_rec_t;

endpackage

// File: rtl/pc_trace_monitor_trace_fifo.sv
// Synchronous FIFO of trace records: push with full flag, valid/ready pop, occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module trace_fifo
  import pc_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  trace_rec_t               push_data_i,
  output logic                     full_o,
  output logic                     pop_valid_o,
  input  logic                     pop_ready_i,
  output trace_rec_t               pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  trace_rec_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign pop_valid_o = (count_q != '0);
  assign full_o      = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop      = pop_valid_o && pop_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push     = push_i && (!full_o || do_pop);
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_trace_monitor.sv
// PC watchpoint/trace monitor: NUM_CH match channels sample a register-file tap into a trace FIFO.
// Define PC_TRACE_HITCOUNT_EN to add per-channel saturating hit counters reported on trc_hit_o.
//
// state   | meaning
// IDLE    | channel disabled
// WATCH   | armed, waiting for a rising PC match
// WAIT    | counting down the programmed delay
// CAPTURE | requesting the rf tap; leaves once granted
module pc_trace_monitor
  import pc_trace_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DELAY_W    = 8,
  parameter int          CYC_W      = 32,
  parameter logic [31:0] HALT_ADDR  = 32'h0,
  localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [31:0]        instr_addr_i,
  input  logic               cfg_we_i,
  input  logic [CH_W-1:0]    cfg_ch_i,
  input  logic               cfg_en_i,
  input  logic [31:0]        cfg_addr_i,
  input  logic [DELAY_W-1:0] cfg_delay_i,
  input  logic [4:0]         cfg_reg_i,
  output logic [4:0]         rf_idx_o,
  input  logic [31:0]        rf_data_i,
  output logic               trc_valid_o,
  input  logic               trc_ready_i,
  output logic [CH_W-1:0]    trc_ch_o,
  output logic [CYC_W-1:0]   trc_cycle_o,
  output logic [31:0]        trc_value_o,
  output logic [HIT_W-1:0]   trc_hit_o,
  output logic               overflow_o,
  output logic               done_o
);

  ch_state_e          state_q [NUM_CH];
  ch_state_e          state_d [NUM_CH];
  logic [DELAY_W-1:0] cnt_q   [NUM_CH];
  logic [DELAY_W-1:0] cnt_d   [NUM_CH];
  logic [31:0]        addr_q  [NUM_CH];
  logic [DELAY_W-1:0] delay_q [NUM_CH];
  logic [4:0]         reg_q   [NUM_CH];

  logic [NUM_CH-1:0]  cfg_sel;
  logic [NUM_CH-1:0]  match;
  logic [NUM_CH-1:0]  grant;
  logic [CYC_W-1:0]   cycle_q;
  logic [31:0]        prev_addr_q;
  logic               halted_q;
  logic               overflow_q;
  logic               done_q;
  logic               halt_now;
  logic               busy;

  logic                        push;
  trace_rec_t                  push_rec;
  trace_rec_t                  head_rec;
  logic                        fifo_valid;
  logic                        fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        unused_head;

  always_comb begin
    halt_now = enable_i && (instr_addr_i == HALT_ADDR);
    busy     = 1'b0;
    cfg_sel  = '0;
    match    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_sel[i] = cfg_we_i && (int'(cfg_ch_i) == i);
      // Edge match: the PC must have just arrived at the watched address.
      match[i]   = (state_q[i] == WATCH) && enable_i && !halt_now && !halted_q &&
                   (instr_addr_i == addr_q[i]) && (prev_addr_q != addr_q[i]);
      busy       = busy || (state_q[i] == WAIT) || (state_q[i] == CAPTURE);
    end
  end

`ifdef PC_TRACE_HITCOUNT_EN
  logic [HIT_W-1:0] hit_q [NUM_CH];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_CH; i++) hit_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_sel[i])                       hit_q[i] <= '0;
        else if (match[i] && hit_q[i] != '1)  hit_q[i] <= hit_q[i] + HIT_W'(1);
      end
    end
  end
`endif

  // Single rf tap: lowest-index channel in CAPTURE wins; a channel being reconfigured drops out.
  always_comb begin
    grant          = '0;
    push           = 1'b0;
    rf_idx_o       = '0;
    push_rec       = '0;
    push_rec.cycle = CYC_W_MAX'(cycle_q);
    push_rec.value = rf_data_i;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!push && state_q[i] == CAPTURE && !cfg_sel[i]) begin
        grant[i]    = 1'b1;
        push        = 1'b1;
        rf_idx_o    = reg_q[i];
        push_rec.ch = CH_W_MAX'(i);
`ifdef PC_TRACE_HITCOUNT_EN
        push_rec.hit = hit_q[i];
`endif
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (cfg_sel[i]) begin
        state_d[i] = cfg_en_i ? WATCH : IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          WATCH: begin
            if (match[i]) begin
              cnt_d[i]   = delay_q[i];
              state_d[i] = (delay_q[i] == '0) ? CAPTURE : WAIT;
            end
          end
          WAIT: begin
            cnt_d[i] = cnt_q[i] - DELAY_W'(1);
            if (cnt_q[i] <= DELAY_W'(1)) state_d[i] = CAPTURE;
          end
          CAPTURE: begin
            if (grant[i]) state_d[i] = WATCH;
          end
          default: state_d[i] = state_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        addr_q[i]  <= '0;
        delay_q[i] <= '0;
        reg_q[i]   <= '0;
      end
      cycle_q     <= '0;
      prev_addr_q <= '0;
      halted_q    <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        if (cfg_sel[i]) begin
          addr_q[i]  <= cfg_addr_i;
          delay_q[i] <= cfg_delay_i;
          reg_q[i]   <= cfg_reg_i;
        end
      end
      if (enable_i) cycle_q <= cycle_q + CYC_W'(1);
      prev_addr_q <= instr_addr_i;
      if (halt_now) halted_q <= 1'b1;
      if (push && fifo_full && !(fifo_valid && trc_ready_i)) overflow_q <= 1'b1;
      if (halted_q && !busy && !fifo_valid) done_q <= 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (reset_i),
    .push_i      (push),
    .push_data_i (push_rec),
    .full_o      (fifo_full),
    .pop_valid_o (fifo_valid),
    .pop_ready_i (trc_ready_i),
    .pop_data_o  (head_rec),
    .count_o     (fifo_count)
  );

  // Storage is not reset, so the head is masked to keep outputs at zero while empty.
  assign trc_valid_o = fifo_valid;
  assign trc_ch_o    = fifo_valid ? head_rec.ch[CH_W-1:0]     : '0;
  assign trc_cycle_o = fifo_valid ? head_rec.cycle[CYC_W-1:0] : '0;
  assign trc_value_o = fifo_valid ? head_rec.value            : '0;
`ifdef PC_TRACE_HITCOUNT_EN
  assign trc_hit_o   = fifo_valid ? head_rec.hit              : '0;
`else
  assign trc_hit_o   = '0;
`endif
  assign overflow_o  = overflow_q;
  assign done_o      = done_q;
  assign unused_head = ^{head_rec, fifo_count};

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Directed bench for pc_trace_monitor (NUM_CH=4, FIFO_DEPTH=2) with hand-computed expectations.
module tb_pc_trace_monitor;

  localparam logic [31:0] A_ADDR = 32'h8002_0024;
  localparam logic [31:0] B_ADDR = 32'h8002_0100;
  localparam logic [31:0] AWAY   = 32'h8002_0030;

`ifdef PC_TRACE_HITCOUNT_EN
  localparam bit HIT_ON = 1'b1;
`else
  localparam bit HIT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] instr_addr;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic        cfg_en;
  logic [31:0] cfg_addr;
  logic [7:0]  cfg_delay;
  logic [4:0]  cfg_reg;
  logic [4:0]  rf_idx;
  logic [31:0] rf_data;
  logic        trc_valid;
  logic        trc_ready;
  logic [1:0]  trc_ch;
  logic [31:0] trc_cycle;
  logic [31:0] trc_value;
  logic [15:0] trc_hit;
  logic        overflow;
  logic        done;

  logic [31:0] regfile [32];
  int total = 0;
  int bad   = 0;
  int tb_cyc;
  int m;
  int m2;

  always #5 clk = ~clk;
  assign rf_data = regfile[rf_idx];

  pc_trace_monitor #(
    .NUM_CH     (4),
    .FIFO_DEPTH (2),
    .DELAY_W    (8),
    .CYC_W      (32),
    .HALT_ADDR  (32'h0)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .enable_i     (enable),
    .instr_addr_i (instr_addr),
    .cfg_we_i     (cfg_we),
    .cfg_ch_i     (cfg_ch),
    .cfg_en_i     (cfg_en),
    .cfg_addr_i   (cfg_addr),
    .cfg_delay_i  (cfg_delay),
    .cfg_reg_i    (cfg_reg),
    .rf_idx_o     (rf_idx),
    .rf_data_i    (rf_data),
    .trc_valid_o  (trc_valid),
    .trc_ready_i  (trc_ready),
    .trc_ch_o     (trc_ch),
    .trc_cycle_o  (trc_cycle),
    .trc_value_o  (trc_value),
    .trc_hit_o    (trc_hit),
    .overflow_o   (overflow),
    .done_o       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] hx(input int n);
    return HIT_ON ? 64'(n) : 64'd0;
  endfunction

  // tb_cyc tracks the value the DUT cycle counter holds after each edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      if (enable && !reset) tb_cyc++;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg(input int ch, input bit en, input logic [31:0] a, input int d, input int r);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_en    = en;
    cfg_addr  = a;
    cfg_delay = 8'(d);
    cfg_reg   = 5'(r);
    tick(1);
    cfg_we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    instr_addr = 32'h8002_0000;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_en     = 1'b0;
    cfg_addr   = '0;
    cfg_delay  = '0;
    cfg_reg    = '0;
    trc_ready  = 1'b0;
    tb_cyc     = 0;
    for (int i = 0; i < 32; i++) regfile[i] = 32'h100 + 32'(i);
    regfile[4] = 32'd7;
    regfile[9] = 32'hABCD_0009;
    regfile[2] = 32'h0000_2222;

    tick(2);
    chk("rst_valid",    64'(trc_valid), 64'd0);
    chk("rst_overflow", 64'(overflow),  64'd0);
    chk("rst_done",     64'(done),      64'd0);
    chk("rst_rf_idx",   64'(rf_idx),    64'd0);
    chk("rst_cycle",    64'(trc_cycle), 64'd0);
    chk("rst_hit",      64'(trc_hit),   64'd0);
    reset  = 1'b0;
    enable = 1'b1;
    tick(1);

    // single hit, delay 5, sample r4
    cfg(0, 1'b1, A_ADDR, 5, 4);
    instr_addr = A_ADDR; m = tb_cyc; tick(1);
    instr_addr = 32'h8002_0028; tick(5);
    chk("t1_rf_idx",   64'(rf_idx),    64'd4);
    chk("t1_not_yet",  64'(trc_valid), 64'd0);
    tick(1);
    chk("t1_valid",    64'(trc_valid), 64'd1);
    chk("t1_ch",       64'(trc_ch),    64'd0);
    chk("t1_value",    64'(trc_value), 64'd7);
    chk("t1_cycle",    64'(trc_cycle), 64'(m + 6));
    chk("t1_hit",      64'(trc_hit),   hx(1));
    chk("t1_rf_idle",  64'(rf_idx),    64'd0);
    trc_ready = 1'b1; tick(1); trc_ready = 1'b0;
    chk("t1_single",   64'(trc_valid), 64'd0);

    // PC held four cycles fires once
    instr_addr = A_ADDR; m = tb_cyc; tick(4);
    instr_addr = AWAY; tick(2);
    chk("t2_rf_idx",   64'(rf_idx),    64'd4);
    tick(1);
    chk("t2_valid",    64'(trc_valid), 64'd1);
    chk("t2_cycle",    64'(trc_cycle), 64'(m + 6));
    chk("t2_hit",      64'(trc_hit),   hx(2));
    trc_ready = 1'b1; tick(1); trc_ready = 1'b0;
    tick(3);
    chk("t2_single",   64'(trc_valid), 64'd0);

    // ch0 and ch2 capture together: ch0 first, ch2 one cycle later
    cfg(2, 1'b1, A_ADDR, 5, 9);
    instr_addr = A_ADDR; m = tb_cyc; tick(1);
    instr_addr = AWAY; tick(5);
    chk("t3_grant_ch0", 64'(rf_idx),    64'd4);
    tick(1);
    chk("t3_grant_ch2", 64'(rf_idx),    64'd9);
    chk("t3_valid",     64'(trc_valid), 64'd1);
    chk("t3_ch0",       64'(trc_ch),    64'd0);
    chk("t3_cyc0",      64'(trc_cycle), 64'(m + 6));
    tick(1);
    chk("t3_stable_ch", 64'(trc_ch),    64'd0);
    chk("t3_stable_cy", 64'(trc_cycle), 64'(m + 6));
    chk("t3_hit0",      64'(trc_hit),   hx(3));
    trc_ready = 1'b1; tick(1);
    chk("t3_ch2",       64'(trc_ch),    64'd2);
    chk("t3_val2",      64'(trc_value), 64'hABCD_0009);
    chk("t3_cyc2",      64'(trc_cycle), 64'(m + 7));
    chk("t3_hit2",      64'(trc_hit),   hx(1));
    tick(1); trc_ready = 1'b0;
    chk("t3_empty",     64'(trc_valid), 64'd0);

    // three captures into a two-entry FIFO with no consumer
    cfg(1, 1'b1, A_ADDR, 5, 2);
    instr_addr = A_ADDR; m = tb_cyc; tick(1);
    instr_addr = AWAY; tick(7);
    chk("t4_third_grant", 64'(rf_idx),   64'd9);
    chk("t4_ovf_before",  64'(overflow), 64'd0);
    tick(1);
    chk("t4_ovf_set",   64'(overflow),  64'd1);
    chk("t4_valid",     64'(trc_valid), 64'd1);
    chk("t4_ch0",       64'(trc_ch),    64'd0);
    chk("t4_cyc0",      64'(trc_cycle), 64'(m + 6));
    trc_ready = 1'b1; tick(1);
    chk("t4_ch1",       64'(trc_ch),    64'd1);
    chk("t4_val1",      64'(trc_value), 64'h2222);
    chk("t4_cyc1",      64'(trc_cycle), 64'(m + 7));
    tick(1); trc_ready = 1'b0;
    chk("t4_drained",   64'(trc_valid), 64'd0);

    // halt while ch1 waits with one record queued
    cfg(0, 1'b1, A_ADDR, 0, 4);
    cfg(1, 1'b1, B_ADDR, 4, 2);
    cfg(2, 1'b0, A_ADDR, 5, 9);
    instr_addr = A_ADDR; m = tb_cyc; tick(1);
    chk("t5_delay0_cap", 64'(rf_idx), 64'd4);
    instr_addr = B_ADDR; m2 = tb_cyc; tick(1);
    chk("t5_q_valid",   64'(trc_valid), 64'd1);
    chk("t5_q_cycle",   64'(trc_cycle), 64'(m + 1));
    chk("t5_q_hit",     64'(trc_hit),   hx(1));
    instr_addr = 32'h0; tick(1);
    instr_addr = A_ADDR; tick(1);
    instr_addr = AWAY; tick(2);
    chk("t5_ch1_cap",   64'(rf_idx),    64'd2);
    chk("t5_done_wait", 64'(done),      64'd0);
    tick(1);
    chk("t5_done_fifo", 64'(done),      64'd0);
    trc_ready = 1'b1; tick(1);
    chk("t5_ch1",       64'(trc_ch),    64'd1);
    chk("t5_val1",      64'(trc_value), 64'h2222);
    chk("t5_cyc1",      64'(trc_cycle), 64'(m2 + 5));
    tick(1);
    chk("t5_empty",     64'(trc_valid), 64'd0);
    chk("t5_done_late", 64'(done),      64'd0);
    tick(1);
    chk("t5_done",      64'(done),      64'd1);
    trc_ready = 1'b0; tick(4);
    chk("t5_no_later",  64'(trc_valid), 64'd0);

    // reset mid-WAIT with a record queued
    chk("t6_ovf_sticky", 64'(overflow), 64'd1);
    instr_addr = AWAY;
    reset = 1'b1; tick(1); reset = 1'b0; tb_cyc = 0;
    chk("t6_clean_done", 64'(done),     64'd0);
    chk("t6_clean_ovf",  64'(overflow), 64'd0);
    cfg(0, 1'b1, A_ADDR, 5, 4);
    cfg(1, 1'b1, B_ADDR, 0, 2);
    instr_addr = B_ADDR; tick(1);
    instr_addr = A_ADDR; tick(1);
    instr_addr = AWAY;   tick(1);
    chk("t6_pre_valid", 64'(trc_valid), 64'd1);
    reset = 1'b1; #1;
    chk("t6_rst_valid", 64'(trc_valid), 64'd0);
    chk("t6_rst_ch",    64'(trc_ch),    64'd0);
    chk("t6_rst_value", 64'(trc_value), 64'd0);
    chk("t6_rst_cycle", 64'(trc_cycle), 64'd0);
    chk("t6_rst_rfidx", 64'(rf_idx),    64'd0);
    tick(1); reset = 1'b0; tb_cyc = 0;
    tick(10);
    chk("t6_no_record", 64'(trc_valid), 64'd0);
    chk("t6_rf_idle",   64'(rf_idx),    64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
